udma_jtag_fifo_cfg_master: RTL and testbench
============================================

// Module: udma_jtag_fifo_cfg_master
// PURPOSE
//  Initiator for the uDMA peripheral config bus (cfg_valid/cfg_rwn/cfg_addr/cfg_data/cfg_ready).
//  Turns single-beat commands into one cfg-bus register access each.
//  Commands come from a debug/JTAG-side command path over a valid/ready handshake.
//  Returns read data, or a write ack, on a response handshake.
//  Sits between the command source and one peripheral register interface.
// PARAMETERS
//  TIMEOUT_CYC  64  max cycles cfg_valid_o is held waiting for cfg_ready_i; 0 = wait forever
// PORTS
//  clk_i        in   1   clock
//  rst_i        in   1   asynchronous, active-high reset
//  cmd_valid_i  in   1   command valid
//  cmd_ready_o  out  1   command accepted when valid&ready
//  cmd_rwn_i    in   1   1 = read, 0 = write
//  cmd_addr_i   in   5   register word address
//  cmd_data_i   in   32  write data (ignored for reads)
//  rsp_valid_o  out  1   response valid
//  rsp_ready_i  in   1   response consumed when valid&ready
//  rsp_data_o   out  32  read data; 0 for writes and for timed-out reads
//  rsp_err_o    out  1   1 = access timed out
//  cfg_valid_o  out  1   cfg-bus request
//  cfg_rwn_o    out  1   cfg-bus direction
//  cfg_addr_o   out  5   cfg-bus address
//  cfg_data_o   out  32  cfg-bus write data
//  cfg_data_i   in   32  cfg-bus read data (combinational from responder)
//  cfg_ready_i  in   1   cfg-bus accept; may be high in the same cycle as cfg_valid_o
// BEHAVIOUR
//  - Reset values: all outputs 0 except cmd_ready_o=1. State=IDLE. Counter=0. Latched cmd/rsp regs=0.
//  - Reset asserted mid-access: the request is dropped and no response is produced.
//  - FSM state IDLE:
//    - cmd_ready_o=1.
//    - On cmd_valid_i: latch rwn/addr/data, clear counter, go to REQ.
//  - FSM state REQ:
//    - cfg_valid_o=1; cfg_rwn_o/addr_o/data_o come from the latched command.
//    - cfg_data_o is forced to 0 when rwn=1.
//    - cfg_ready_i=1: capture cfg_data_i into rsp_data if read (0 if write), err=0, go to RSP.
//    - Otherwise, if TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1: rsp_data=0, err=1, go to RSP (no cfg beat).
//    - Otherwise counter++. Counter width is $clog2(TIMEOUT_CYC+1), so it never wraps.
//  - FSM state RSP:
//    - rsp_valid_o=1; rsp_data_o and rsp_err_o held stable.
//    - On rsp_ready_i: go to IDLE.
//  - Outside REQ, all cfg_* outputs are 0 (idle bus presents address 0, no request).
//  - Outside IDLE, cmd_ready_o=0. Exactly one outstanding command; no command pipelining.
//  - Latency (cfg_ready_i tied 1):
//    - Cmd accepted at edge N.
//    - cfg_valid_o high in cycle N+1.
//    - rsp_valid_o high in cycle N+2.
//    - If rsp_ready_i is high, cmd_ready_o is high again in cycle N+3.
//  - Every command produces exactly one response, writes included.
//  - Response is held indefinitely under rsp_ready_i=0 backpressure.
//  - cmd_valid_i in a non-IDLE state is ignored; the command is not latched.
//  - cfg_data_i is sampled only in the cycle cfg_valid_o&cfg_ready_i. The value at other times is don't-care.
// TESTING
//  - Write: cmd{rwn=0,addr=5'h01,data=32'h0000_0040}, ready tied 1:
//    -> one cfg beat with addr=1, data=0x40, rwn=0.
//    -> rsp_valid 2 cycles after accept, data=0, err=0.
//  - Read: cmd{rwn=1,addr=5'h09}, responder drives cfg_data_i=32'h01B2_0307:
//    -> rsp_data_o=32'h01B2_0307, err=0.
//    -> cfg_data_o=0 during the beat.
//  - Wait states: cfg_ready_i low for 5 cycles then high:
//    -> cfg_valid_o held 6 cycles, address/data stable throughout, no error.
//  - Timeout, TIMEOUT_CYC=4, cfg_ready_i stuck 0:
//    -> cfg_valid_o high exactly 4 cycles.
//    -> rsp_err_o=1, rsp_data_o=0.
//    -> back to IDLE after rsp_ready_i.
//  - Backpressure: rsp_ready_i=0 for 10 cycles with cmd_valid_i=1 and a new command:
//    -> rsp held stable, cmd_ready_o=0, second command accepted only after the response handshake.
//  - rst_i pulsed while in REQ:
//    -> next cycle cfg_valid_o=0, rsp_valid_o=0, cmd_ready_o=1.
//    -> a subsequent read completes normally.

Source files
------------

// File: rtl/udma_jtag_fifo_cfg_master.sv
// Single-outstanding initiator for the uDMA peripheral config bus: one command in,
// one cfg-bus access, one response (read data or write ack, with a timeout error flag).
module udma_jtag_fifo_cfg_master #(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_rwn_i,
   input  logic [4:0]  cmd_addr_i,
   input  logic [31:0] cmd_data_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        rsp_err_o,
   output logic        cfg_valid_o,
   output logic        cfg_rwn_o,
   output logic [4:0]  cfg_addr_o,
   output logic [31:0] cfg_data_o,
   input  logic [31:0] cfg_data_i,
   input  logic        cfg_ready_i
);

   // A zero timeout still needs a legal one-bit counter; it is simply never advanced.
   localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
   localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RSP  = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             lat_rwn;
   logic [4:0]       lat_addr;
   logic [31:0]      lat_data;
   logic [31:0]      rsp_data_q;
   logic             rsp_err_q;
   logic             in_req;
   logic             in_rsp;
   logic             timeout_hit;

   assign in_req      = (state == ST_REQ);
   assign in_rsp      = (state == ST_RSP);
   assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         lat_rwn    <= 1'b0;
         lat_addr   <= '0;
         lat_data   <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  lat_rwn  <= cmd_rwn_i;
                  lat_addr <= cmd_addr_i;
                  lat_data <= cmd_data_i;
                  cnt      <= '0;
                  state    <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (cfg_ready_i) begin
                  rsp_data_q <= lat_rwn ? cfg_data_i : 32'h0;
                  rsp_err_q  <= 1'b0;
                  state      <= ST_RSP;
               end else if (timeout_hit) begin
                  rsp_data_q <= 32'h0;
                  rsp_err_q  <= 1'b1;
                  state      <= ST_RSP;
               end else if (TIMEOUT_EN) begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RSP: begin
               if (rsp_ready_i) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The bus is driven to all-zero whenever no request is in flight.
   assign cmd_ready_o = (state == ST_IDLE);
   assign cfg_valid_o = in_req;
   assign cfg_rwn_o   = in_req & lat_rwn;
   assign cfg_addr_o  = in_req ? lat_addr : 5'h0;
   assign cfg_data_o  = (in_req && !lat_rwn) ? lat_data : 32'h0;
   assign rsp_valid_o = in_rsp;
   assign rsp_data_o  = in_rsp ? rsp_data_q : 32'h0;
   assign rsp_err_o   = in_rsp & rsp_err_q;

endmodule

// File: tb/tb_udma_jtag_fifo_cfg_master.sv
// Bench for udma_jtag_fifo_cfg_master: directed commands with scoreboard queues for
// cfg beats and responses, plus a second instance with a short timeout.
module tb_udma_jtag_fifo_cfg_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_rwn;
   logic [4:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_data;
   logic        cfg_valid, cfg_rwn, cfg_ready;
   logic [4:0]  cfg_addr;
   logic [31:0] cfg_wdata, cfg_rdata;

   logic        t_cmd_valid, t_cmd_ready, t_cmd_rwn;
   logic [4:0]  t_cmd_addr;
   logic [31:0] t_cmd_data;
   logic        t_rsp_valid, t_rsp_ready, t_rsp_err;
   logic [31:0] t_rsp_data;
   logic        t_cfg_valid, t_cfg_rwn, t_cfg_ready;
   logic [4:0]  t_cfg_addr;
   logic [31:0] t_cfg_wdata, t_cfg_rdata;

   int total = 0;
   int bad   = 0;

   logic [37:0] cfg_q[$];
   logic [32:0] rsp_q[$];
   logic [32:0] t_rsp_q[$];

   always #5 clk = ~clk;

   udma_jtag_fifo_cfg_master dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_rwn_i(cmd_rwn),
      .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
      .cfg_valid_o(cfg_valid), .cfg_rwn_o(cfg_rwn), .cfg_addr_o(cfg_addr), .cfg_data_o(cfg_wdata),
      .cfg_data_i(cfg_rdata), .cfg_ready_i(cfg_ready)
   );

   udma_jtag_fifo_cfg_master #(.TIMEOUT_CYC(4)) dut_to (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(t_cmd_valid), .cmd_ready_o(t_cmd_ready), .cmd_rwn_i(t_cmd_rwn),
      .cmd_addr_i(t_cmd_addr), .cmd_data_i(t_cmd_data),
      .rsp_valid_o(t_rsp_valid), .rsp_ready_i(t_rsp_ready), .rsp_data_o(t_rsp_data), .rsp_err_o(t_rsp_err),
      .cfg_valid_o(t_cfg_valid), .cfg_rwn_o(t_cfg_rwn), .cfg_addr_o(t_cfg_addr), .cfg_data_o(t_cfg_wdata),
      .cfg_data_i(t_cfg_rdata), .cfg_ready_i(t_cfg_ready)
   );

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitors pop the scoreboard whenever a cfg beat or a response handshake happens.
   always @(negedge clk) begin
      if (!rst) begin
         if (cfg_valid && cfg_ready) begin
            if (cfg_q.size() == 0) check_output("cfg_unexpected_beat", 64'd1, 64'd0);
            else check_output("cfg_beat", {26'd0, cfg_rwn, cfg_addr, cfg_wdata}, {26'd0, cfg_q.pop_front()});
         end
         if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) check_output("rsp_unexpected", 64'd1, 64'd0);
            else check_output("rsp_data_err", {31'd0, rsp_err, rsp_data}, {31'd0, rsp_q.pop_front()});
         end
         if (t_rsp_valid && t_rsp_ready) begin
            if (t_rsp_q.size() == 0) check_output("t_rsp_unexpected", 64'd1, 64'd0);
            else check_output("t_rsp_data_err", {31'd0, t_rsp_err, t_rsp_data}, {31'd0, t_rsp_q.pop_front()});
         end
         if (t_cfg_valid && t_cfg_ready) check_output("t_cfg_unexpected_beat", 64'd1, 64'd0);
      end
   end

   // Returns just after the accepting clock edge.
   task automatic apply_stimulus(input logic rwn, input logic [4:0] addr, input logic [31:0] data);
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check_output("cmd_ready_wait", 64'd0, 64'd1);
      cmd_valid = 1'b1;
      cmd_rwn   = rwn;
      cmd_addr  = addr;
      cmd_data  = data;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int vcnt;
      int n;
      rst = 1'b1;
      cmd_valid = 0; cmd_rwn = 0; cmd_addr = 0; cmd_data = 0;
      rsp_ready = 1; cfg_ready = 1; cfg_rdata = 0;
      t_cmd_valid = 0; t_cmd_rwn = 0; t_cmd_addr = 0; t_cmd_data = 0;
      t_rsp_ready = 0; t_cfg_ready = 0; t_cfg_rdata = 32'hFFFF_FFFF;

      repeat (2) @(negedge clk);
      check_output("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check_output("rst_cfg_valid", {63'd0, cfg_valid}, 64'd0);
      check_output("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check_output("rst_cfg_addr", {59'd0, cfg_addr}, 64'd0);
      check_output("rst_rsp_data_err", {31'd0, rsp_err, rsp_data}, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Write with ready tied high: beat one cycle after accept, response one after that.
      cfg_q.push_back({1'b0, 5'h01, 32'h0000_0040});
      rsp_q.push_back({1'b0, 32'h0});
      apply_stimulus(1'b0, 5'h01, 32'h0000_0040);
      @(negedge clk);
      check_output("wr_cfg_valid_n1", {63'd0, cfg_valid}, 64'd1);
      check_output("wr_rsp_valid_n1", {63'd0, rsp_valid}, 64'd0);
      @(negedge clk);
      check_output("wr_rsp_valid_n2", {63'd0, rsp_valid}, 64'd1);
      check_output("wr_cfg_valid_n2", {63'd0, cfg_valid}, 64'd0);
      @(negedge clk);
      check_output("wr_cmd_ready_n3", {63'd0, cmd_ready}, 64'd1);

      // Read: write-data pins carry junk that must not reach the bus.
      cfg_rdata = 32'h01B2_0307;
      cfg_q.push_back({1'b1, 5'h09, 32'h0});
      rsp_q.push_back({1'b0, 32'h01B2_0307});
      apply_stimulus(1'b1, 5'h09, 32'hFFFF_FFFF);
      @(negedge clk);
      check_output("rd_cfg_wdata_zero", {32'd0, cfg_wdata}, 64'd0);
      repeat (2) @(negedge clk);
      cfg_rdata = 32'h0;

      // Wait states: ready low for 5 request cycles, then high.
      cfg_ready = 1'b0;
      cfg_q.push_back({1'b0, 5'h1F, 32'hA5A5_5A5A});
      rsp_q.push_back({1'b0, 32'h0});
      apply_stimulus(1'b0, 5'h1F, 32'hA5A5_5A5A);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check_output("ws_cfg_valid", {63'd0, cfg_valid}, 64'd1);
         check_output("ws_cfg_addr", {59'd0, cfg_addr}, 64'h1F);
         check_output("ws_cfg_wdata", {32'd0, cfg_wdata}, 64'hA5A5_5A5A);
         if (k == 5) begin
            @(posedge clk);
            #1 cfg_ready = 1'b1;
         end
      end
      @(negedge clk);
      check_output("ws_cfg_valid_done", {63'd0, cfg_valid}, 64'd0);
      check_output("ws_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      @(negedge clk);

      // Backpressure with a second command already waiting on the pins.
      rsp_ready = 1'b0;
      cfg_rdata = 32'h1234_5678;
      cfg_q.push_back({1'b1, 5'h04, 32'h0});
      rsp_q.push_back({1'b0, 32'h1234_5678});
      apply_stimulus(1'b1, 5'h04, 32'hFFFF_0000);
      cmd_valid = 1'b1; cmd_rwn = 1'b0; cmd_addr = 5'h06; cmd_data = 32'h0000_0077;
      cfg_q.push_back({1'b0, 5'h06, 32'h0000_0077});
      rsp_q.push_back({1'b0, 32'h0});
      @(posedge clk);
      #1 cfg_rdata = 32'hBAD0_BAD0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check_output("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
         check_output("bp_rsp_data", {32'd0, rsp_data}, 64'h1234_5678);
         check_output("bp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
         check_output("bp_cfg_valid", {63'd0, cfg_valid}, 64'd0);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_output("bp_cmd_ready_after", {63'd0, cmd_ready}, 64'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      check_output("bp_second_cfg_valid", {63'd0, cfg_valid}, 64'd1);
      check_output("bp_second_cfg_addr", {59'd0, cfg_addr}, 64'h06);
      repeat (2) @(negedge clk);
      cfg_rdata = 32'h0;

      // Timeout instance: cfg_ready stuck low, four request cycles then an error response.
      t_rsp_q.push_back({1'b1, 32'h0});
      @(negedge clk);
      t_cmd_valid = 1'b1; t_cmd_rwn = 1'b1; t_cmd_addr = 5'h02;
      @(posedge clk);
      #1 t_cmd_valid = 1'b0;
      vcnt = 0;
      n = 0;
      while (!t_rsp_valid && n < 30) begin
         @(negedge clk);
         if (t_cfg_valid) vcnt++;
         n++;
      end
      check_output("to_cfg_valid_cycles", 64'(vcnt), 64'd4);
      check_output("to_rsp_valid", {63'd0, t_rsp_valid}, 64'd1);
      check_output("to_rsp_err", {63'd0, t_rsp_err}, 64'd1);
      check_output("to_cmd_ready_busy", {63'd0, t_cmd_ready}, 64'd0);
      @(posedge clk);
      #1 t_rsp_ready = 1'b1;
      @(posedge clk);
      #1 t_rsp_ready = 1'b0;
      @(negedge clk);
      check_output("to_idle_cmd_ready", {63'd0, t_cmd_ready}, 64'd1);
      check_output("to_idle_rsp_valid", {63'd0, t_rsp_valid}, 64'd0);

      // Reset pulsed while a read is stuck in the request phase; nothing may come out.
      cfg_ready = 1'b0;
      rsp_ready = 1'b1;
      apply_stimulus(1'b1, 5'h07, 32'h0);
      @(negedge clk);
      check_output("rm_cfg_valid_before", {63'd0, cfg_valid}, 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_output("rm_cfg_valid", {63'd0, cfg_valid}, 64'd0);
      check_output("rm_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check_output("rm_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      cfg_ready = 1'b1;
      cfg_rdata = 32'hCAFE_F00D;
      cfg_q.push_back({1'b1, 5'h0A, 32'h0});
      rsp_q.push_back({1'b0, 32'hCAFE_F00D});
      apply_stimulus(1'b1, 5'h0A, 32'h5555_5555);
      repeat (4) @(negedge clk);

      check_output("cfg_q_drained", 64'(cfg_q.size()), 64'd0);
      check_output("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
      check_output("t_rsp_q_drained", 64'(t_rsp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
